dct8_row_stage: RTL



---
 rtl/dct8_row_stage.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/dct8_row_stage.sv
// ---------------------------------------------------------------------------
// dct8_row_stage
// Streaming 8-point 1D forward DCT, placed ahead of the 8x8 transpose buffer.
// Samples arrive one per enabled cycle, rows of 8 in raster order. Each row
// produces 8 coefficients, k = 0..7, one per enabled cycle.
//
// Ports:
//   clk      clock
//   rst      synchronous, active-high reset
//   ena_in   sample valid and pipeline advance; all state holds when low
//   S_in     signed input sample (IN_W)
//   S_out    signed DCT coefficient, registered (OUT_W)
//   ena_out  registered; high for one cycle per new S_out value
//   inv      (DCT_INVERSE_EN only) selects the transposed ROM, giving the
//            1D IDCT; sampled when a row's last sample is captured
//
// Optional feature macro: DCT_INVERSE_EN (undefined = forward DCT only).
//
// The cosine ROM holds the FRAC = 12 values of 2^FRAC * c(k)/2 *
// cos((2n+1)k*pi/16), where c(0) = 1/sqrt(2) and c(k>0) = 1.
// ---------------------------------------------------------------------------
module dct8_row_stage #(
   parameter int IN_W   = 12,
   parameter int OUT_W  = 12,
   parameter int COEF_W = 12,
   parameter int FRAC   = 12
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ena_in,
`ifdef DCT_INVERSE_EN
   input  logic                    inv,
`endif
   input  logic signed [IN_W-1:0]  S_in,
   output logic signed [OUT_W-1:0] S_out,
   output logic                    ena_out
);

   localparam int PROD_W = IN_W + COEF_W;
   localparam int SUM_W  = PROD_W + 3;

   localparam logic signed [SUM_W-1:0] HALF  = SUM_W'(1) << (FRAC - 1);
   localparam logic signed [SUM_W-1:0] MAX_V = SUM_W'((1 << (OUT_W - 1)) - 1);
   localparam logic signed [SUM_W-1:0] MIN_V = -MAX_V - SUM_W'(1);

   // Cosine ROM entry C[k][n]. The angle index m = (2n+1)k mod 32 is folded
   // onto a quarter wave; m == 0 only occurs for k == 0, where c(0) applies.
   function automatic logic signed [COEF_W-1:0] coef(input logic [2:0] k,
                                                      input logic [2:0] n);
      int m;
      int mag;
      logic neg;
      m = ((2 * int'(n) + 1) * int'(k)) % 32;
      if (m > 16) m = 32 - m;
      neg = (m > 8);
      if (neg) m = 16 - m;
      case (m)
         0:       mag = 1448;
         1:       mag = 2009;
         2:       mag = 1892;
         3:       mag = 1703;
         4:       mag = 1448;
         5:       mag = 1138;
         6:       mag = 784;
         7:       mag = 400;
         default: mag = 0;
      endcase
      coef = COEF_W'(neg ? -mag : mag);
   endfunction

   function automatic logic signed [PROD_W-1:0] mul(input logic signed [IN_W-1:0]   a,
                                                    input logic signed [COEF_W-1:0] b);
      mul = PROD_W'(a) * PROD_W'(b);
   endfunction

   // Round half up, then drop the fractional bits with an arithmetic shift.
   function automatic logic signed [SUM_W-1:0] rnd(input logic signed [SUM_W-1:0] s);
      rnd = (s + HALF) >>> FRAC;
   endfunction

   function automatic logic signed [OUT_W-1:0] sat(input logic signed [SUM_W-1:0] r);
      if (r > MAX_V)      sat = OUT_W'(MAX_V);
      else if (r < MIN_V) sat = OUT_W'(MIN_V);
      else                sat = OUT_W'(r);
   endfunction

   logic signed [IN_W-1:0]   x_buf [0:7];
   logic signed [IN_W-1:0]   h_p0  [0:7];
   logic signed [PROD_W-1:0] prod_p1 [0:7];
   logic signed [SUM_W-1:0]  sum_p1;
   logic [2:0]               n_cnt;
   logic [2:0]               k_cnt;
   logic                     armed_p0;
   logic                     inv_p0;
   logic                     vld_p1;

`ifdef DCT_INVERSE_EN
   logic inv_s;
   assign inv_s = inv;
`else
   logic inv_s;
   assign inv_s = 1'b0;
`endif

   // Control: counters, arm flag, valid bits and the output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         n_cnt    <= '0;
         k_cnt    <= '0;
         armed_p0 <= 1'b0;
         vld_p1   <= 1'b0;
         ena_out  <= 1'b0;
         S_out    <= '0;
      end else if (ena_in) begin
         n_cnt <= n_cnt + 3'd1;
         if (armed_p0) begin
            vld_p1 <= 1'b1;
            k_cnt  <= k_cnt + 3'd1;
            if (k_cnt == 3'd7) armed_p0 <= 1'b0;
         end else begin
            vld_p1 <= 1'b0;
         end
         // A completed row re-arms even on the cycle the previous row ends.
         if (n_cnt == 3'd7) begin
            k_cnt    <= '0;
            armed_p0 <= 1'b1;
         end
         if (vld_p1) begin
            S_out   <= sat(rnd(sum_p1));
            ena_out <= 1'b1;
         end else begin
            ena_out <= 1'b0;
         end
      end else begin
         ena_out <= 1'b0;
      end
   end

   // Stage 0 -> 1: sample capture, row hold, per-k products.
   always_ff @(posedge clk) begin
      if (ena_in) begin
         x_buf[n_cnt] <= S_in;
         if (n_cnt == 3'd7) begin
            for (int i = 0; i < 7; i++) h_p0[i] <= x_buf[i];
            h_p0[7] <= S_in;
            inv_p0  <= inv_s;
         end
         if (armed_p0) begin
            for (int i = 0; i < 8; i++)
               prod_p1[i] <= mul(h_p0[i], inv_p0 ? coef(3'(i), k_cnt)
                                                 : coef(k_cnt, 3'(i)));
         end
      end
   end

   // Stage 1 -> 2: full-width accumulation feeding the output register.
   always_comb begin
      sum_p1 = '0;
      for (int i = 0; i < 8; i++) sum_p1 = sum_p1 + SUM_W'(prod_p1[i]);
   end

endmodule
